// File: rtl/axi_mem_pkg.sv
// rtl/axi_mem_pkg.sv - shared types for the AXI burst memory responder
//
// Purpose: burst/response encodings, responder FSM states and the captured
// command record shared by the top and the address generator.
package axi_mem_pkg;

  localparam int AXI_ADDR_W = 64;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_R_WAIT,
    S_R_BURST,
    S_W_DATA,
    S_W_RESP
  } state_t;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    burst_t                burst;
  } cmd_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// rtl/axi_burst_addr_gen.sv - next beat address and error classification
//
// Purpose: from the captured command, produce the next beat address and the
// word index / error flag for both the current and the next beat.
// Ports:
//   cmd       in   captured command (current beat address, len, size, burst)
//   next_addr out  address of the beat after the current one
//   cur_idx   out  array index of the current beat
//   cur_err   out  current beat is an error beat
//   next_idx  out  array index of the next beat
//   next_err  out  next beat is an error beat
module axi_burst_addr_gen
  import axi_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int MEM_WORDS  = 4096
) (
  input  cmd_t                        cmd,
  output logic [AXI_ADDR_W-1:0]       next_addr,
  output logic [$clog2(MEM_WORDS)-1:0] cur_idx,
  output logic                        cur_err,
  output logic [$clog2(MEM_WORDS)-1:0] next_idx,
  output logic                        next_err
);

  localparam int BPB     = DATA_WIDTH / 8;
  localparam int BPB_LOG = $clog2(BPB);
  localparam int IDX_W   = $clog2(MEM_WORDS);
  localparam logic [AXI_ADDR_W-1:0] ONE_A   = AXI_ADDR_W'(1);
  localparam logic [AXI_ADDR_W-1:0] BPB_A   = AXI_ADDR_W'(BPB);
  localparam logic [AXI_ADDR_W-1:0] WORDS_A = AXI_ADDR_W'(MEM_WORDS);
  // Addresses roll over at 2^ADDR_WIDTH, not at the internal 64-bit width.
  localparam logic [AXI_ADDR_W-1:0] ADDR_MASK = {AXI_ADDR_W{1'b1}} >> (AXI_ADDR_W - ADDR_WIDTH);

  logic [AXI_ADDR_W-1:0] incr;
  logic [AXI_ADDR_W-1:0] wrap_mask;
  logic [AXI_ADDR_W-1:0] cur_word;
  logic [AXI_ADDR_W-1:0] next_word;
  logic                  cmd_err;

  always_comb begin
    incr      = cmd.addr + BPB_A;
    wrap_mask = ((AXI_ADDR_W'(cmd.len) + ONE_A) << BPB_LOG) - ONE_A;
    case (cmd.burst)
      BURST_INCR: next_addr = incr & ADDR_MASK;
      BURST_WRAP: next_addr = ((cmd.addr & ~wrap_mask) | (incr & wrap_mask)) & ADDR_MASK;
      default:    next_addr = cmd.addr;
    endcase

    // Command-level faults make every beat of the burst an error beat.
    cmd_err = (cmd.size != 3'(BPB_LOG)) || (cmd.burst == BURST_RSVD) ||
              ((cmd.burst == BURST_WRAP) && !(cmd.len inside {8'd1, 8'd3, 8'd7, 8'd15}));

    cur_word  = cmd.addr >> BPB_LOG;
    next_word = next_addr >> BPB_LOG;
    cur_idx   = cur_word[IDX_W-1:0];
    next_idx  = next_word[IDX_W-1:0];
    cur_err   = cmd_err || (cur_word >= WORDS_A);
    next_err  = cmd_err || (next_word >= WORDS_A);
  end

endmodule

// File: rtl/axi_burst_mem_responder.sv
// rtl/axi_burst_mem_responder.sv - AXI burst responder backed by an on-chip array
//
// Purpose: accepts one read or write burst at a time and serves it from an
// internal word array; out-of-range or malformed beats answer SLVERR.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   s_axi_ar*                  read address channel (addr/len/size/burst/valid/ready)
//   s_axi_r*                   read data channel (data/resp/last/valid/ready)
//   s_axi_aw*                  write address channel (addr/len/size/burst/valid/ready)
//   s_axi_w*                   write data channel (data/last/valid/ready)
//   s_axi_b*                   write response channel (resp/valid/ready)
module axi_burst_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 64,
  parameter int MEM_WORDS    = 4096,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int LAT_W = $clog2(READ_LATENCY) + 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(READ_LATENCY - 1);

  state_t                state;
  cmd_t                  cmd;
  logic [7:0]            beat;
  logic [LAT_W-1:0]      lat;
  logic                  werr;
  logic                  idle_ready;
  logic [AXI_ADDR_W-1:0] next_addr;
  logic [IDX_W-1:0]      cur_idx;
  logic [IDX_W-1:0]      next_idx;
  logic                  cur_err;
  logic                  next_err;
  logic                  wlast_bad;
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  axi_burst_addr_gen #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .MEM_WORDS (MEM_WORDS)
  ) u_addr_gen (
    .cmd      (cmd),
    .next_addr(next_addr),
    .cur_idx  (cur_idx),
    .cur_err  (cur_err),
    .next_idx (next_idx),
    .next_err (next_err)
  );

  // idle_ready is a register so both address readies are low during reset;
  // a pending read blocks the write address so reads win a same-cycle tie.
  assign s_axi_arready = idle_ready;
  assign s_axi_awready = idle_ready & ~s_axi_arvalid;
  assign wlast_bad     = s_axi_wlast != (beat == cmd.len);

  // Array has no reset: contents survive reset, including beats of an aborted burst.
  always_ff @(posedge clk) begin
    if (state == S_W_DATA && s_axi_wvalid && !cur_err) mem[cur_idx] <= s_axi_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      cmd          <= '0;
      beat         <= '0;
      lat          <= '0;
      werr         <= 1'b0;
      idle_ready   <= 1'b0;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
      s_axi_rlast  <= 1'b0;
      s_axi_wready <= 1'b0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
    end else begin
      case (state)
        S_IDLE: begin
          idle_ready <= 1'b1;
          if (idle_ready && s_axi_arvalid) begin
            idle_ready <= 1'b0;
            cmd        <= '{addr: AXI_ADDR_W'(s_axi_araddr), len: s_axi_arlen,
                            size: s_axi_arsize, burst: burst_t'(s_axi_arburst)};
            beat       <= '0;
            lat        <= LAT_INIT;
            state      <= S_R_WAIT;
          end else if (idle_ready && s_axi_awvalid) begin
            idle_ready   <= 1'b0;
            cmd          <= '{addr: AXI_ADDR_W'(s_axi_awaddr), len: s_axi_awlen,
                              size: s_axi_awsize, burst: burst_t'(s_axi_awburst)};
            beat         <= '0;
            werr         <= 1'b0;
            s_axi_wready <= 1'b1;
            state        <= S_W_DATA;
          end
        end
        S_R_WAIT: begin
          if (lat == '0) begin
            state        <= S_R_BURST;
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= cur_err ? '0 : mem[cur_idx];
            s_axi_rresp  <= cur_err ? RESP_SLVERR : RESP_OKAY;
            s_axi_rlast  <= (cmd.len == 8'd0);
          end else begin
            lat <= lat - LAT_W'(1);
          end
        end
        S_R_BURST: begin
          if (s_axi_rready) begin
            if (beat == cmd.len) begin
              state        <= S_IDLE;
              idle_ready   <= 1'b1;
              s_axi_rvalid <= 1'b0;
              s_axi_rdata  <= '0;
              s_axi_rresp  <= RESP_OKAY;
              s_axi_rlast  <= 1'b0;
            end else begin
              // Preload the following beat so rdata is registered, not a raw array read.
              beat        <= beat + 8'd1;
              cmd.addr    <= next_addr;
              s_axi_rdata <= next_err ? '0 : mem[next_idx];
              s_axi_rresp <= next_err ? RESP_SLVERR : RESP_OKAY;
              s_axi_rlast <= ((beat + 8'd1) == cmd.len);
            end
          end
        end
        S_W_DATA: begin
          if (s_axi_wvalid) begin
            if (beat == cmd.len) begin
              state        <= S_W_RESP;
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= (werr || cur_err || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
            end else begin
              beat     <= beat + 8'd1;
              cmd.addr <= next_addr;
              werr     <= werr || cur_err || wlast_bad;
            end
          end
        end
        S_W_RESP: begin
          if (s_axi_bready) begin
            state        <= S_IDLE;
            idle_ready   <= 1'b1;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_mem_responder.sv
// tb/tb_axi_burst_mem_responder.sv - self-checking bench for axi_burst_mem_responder
module tb_axi_burst_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid;
  logic        rready = 1'b1;
  logic [63:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [63:0] wdata = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;

  always #5 clk = ~clk;

  axi_burst_mem_responder dut (
    .clk(clk), .reset(reset),
    .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready)
  );

  typedef struct {
    logic [63:0] d;
    bit          known;
    logic [1:0]  resp;
    bit          last;
  } rbeat_t;

  int          checks = 0;
  int          passed = 0;
  logic [63:0] mm [4096];
  bit          mk [4096];
  rbeat_t      rq[$];
  logic [1:0]  bq[$];
  logic [63:0] rlog[$];
  logic [63:0] rresp_log[$];
  logic [63:0] expq[$];
  logic [63:0] expr[$];
  logic [1:0]  last_bresp = 2'b11;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference rules: beat addresses and error classification in plain arithmetic.
  function automatic bit beat_err(input logic [63:0] a, input int len, input int size, input int burst);
    return (a / 64'd8 >= 64'd4096) || (size != 3) || (burst == 3) ||
           (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  function automatic logic [63:0] model_next(input logic [63:0] a, input int len, input int burst);
    logic [63:0] t, base;
    if (burst == 1) return a + 64'd8;
    if (burst == 2) begin
      t    = 64'(len + 1) * 64'd8;
      base = a - (a % t);
      return base + ((a - base + 64'd8) % t);
    end
    return a;
  endfunction

  task automatic push_read(input logic [63:0] a, input int len, input int size, input int burst);
    logic [63:0] ad;
    rbeat_t b;
    ad = a;
    for (int i = 0; i <= len; i++) begin
      if (beat_err(ad, len, size, burst)) begin
        b.d = '0; b.known = 1'b1; b.resp = 2'b10;
      end else begin
        b.d = mm[ad[14:3]]; b.known = mk[ad[14:3]]; b.resp = 2'b00;
      end
      b.last = (i == len);
      rq.push_back(b);
      ad = model_next(ad, len, burst);
    end
  endtask

  task automatic model_write(input logic [63:0] a, input int len, input int size, input int burst,
                             input logic [63:0] base, input int early, input int nbeats, input bit push_b);
    logic [63:0] ad;
    bit bad;
    ad = a;
    bad = (early >= 0 && early != len);
    for (int i = 0; i <= len; i++) begin
      if (beat_err(ad, len, size, burst)) bad = 1'b1;
      else if (i < nbeats) begin
        mm[ad[14:3]] = base + 64'(i);
        mk[ad[14:3]] = 1'b1;
      end
      ad = model_next(ad, len, burst);
    end
    if (push_b) bq.push_back(bad ? 2'b10 : 2'b00);
  endtask

  // Compare process: every negedge, DUT outputs against the model queues.
  always @(negedge clk) begin
    if (!reset) begin
      chk("reset_outputs", {arready, awready, rvalid, rlast, wready, bvalid, rresp, bresp}, 64'd0);
      chk("reset_rdata", rdata, 64'd0);
    end else begin
      if (rvalid) begin
        if (rq.size() == 0) chk("r_spurious", {63'd0, rvalid}, 64'd0);
        else begin
          if (rq[0].known) chk("rdata", rdata, rq[0].d);
          chk("rresp", {62'd0, rresp}, {62'd0, rq[0].resp});
          chk("rlast", {63'd0, rlast}, {63'd0, rq[0].last});
          if (rready) begin
            rlog.push_back(rdata);
            rresp_log.push_back({62'd0, rresp});
            rq.delete(0);
          end
        end
      end
      if (bvalid) begin
        if (bq.size() == 0) chk("b_spurious", {63'd0, bvalid}, 64'd0);
        else begin
          chk("bresp", {62'd0, bresp}, {62'd0, bq[0]});
          if (bready) begin
            last_bresp = bresp;
            bq.delete(0);
          end
        end
      end
    end
  end

  task automatic ar_go(input logic [63:0] a, input int len, input int size, input int burst);
    int n;
    araddr = a; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst); arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 50) begin @(negedge clk); n++; end
    chk("ar_ready", {63'd0, arready}, 64'd1);
    @(posedge clk); #1 arvalid = 1'b0;
  endtask

  task automatic aw_go(input logic [63:0] a, input int len, input int size, input int burst);
    int n;
    awaddr = a; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst); awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!awready && n < 50) begin @(negedge clk); n++; end
    chk("aw_ready", {63'd0, awready}, 64'd1);
    @(posedge clk); #1 awvalid = 1'b0;
  endtask

  task automatic w_beats(input int len, input logic [63:0] base, input int early);
    int n;
    for (int i = 0; i <= len; i++) begin
      wdata = base + 64'(i); wlast = (i == len) || (i == early); wvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!wready && n < 50) begin @(negedge clk); n++; end
      chk("w_ready", {63'd0, wready}, 64'd1);
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic wait_read_done();
    int n;
    n = 0;
    while (rq.size() > 0 && n < 600) begin @(posedge clk); #1; n++; end
    chk("r_done", 64'(rq.size()), 64'd0);
  endtask

  task automatic wait_b_done();
    int n;
    n = 0;
    while (bq.size() > 0 && n < 50) begin @(posedge clk); #1; n++; end
    chk("b_done", 64'(bq.size()), 64'd0);
  endtask

  task automatic do_read(input logic [63:0] a, input int len, input int size, input int burst);
    rlog.delete(); rresp_log.delete();
    push_read(a, len, size, burst);
    ar_go(a, len, size, burst);
    wait_read_done();
  endtask

  task automatic do_write(input logic [63:0] a, input int len, input int size, input int burst,
                          input logic [63:0] base, input int early);
    model_write(a, len, size, burst, base, early, len + 1, 1'b1);
    aw_go(a, len, size, burst);
    w_beats(len, base, early);
    wait_b_done();
  endtask

  task automatic chk_logs(input string name);
    chk({name, "_count"}, 64'(rlog.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size() && i < rlog.size(); i++) chk({name, "_data"}, rlog[i], expq[i]);
    for (int i = 0; i < expr.size() && i < rresp_log.size(); i++) chk({name, "_resp"}, rresp_log[i], expr[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n;
    bit stalled;
    for (int i = 0; i < 4096; i++) begin mm[i] = '0; mk[i] = 1'b0; end
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_arready", {63'd0, arready}, 64'd1);
    chk("idle_awready", {63'd0, awready}, 64'd1);

    // 1: mem[i]=i, then WRAP read from 0x28
    do_write(64'h0, 7, 3, 1, 64'h0, -1);
    chk("t1_bresp", {62'd0, last_bresp}, 64'd0);
    rlog.delete(); rresp_log.delete();
    push_read(64'h28, 7, 3, 2);
    expq = '{64'd5, 64'd6, 64'd7, 64'd0, 64'd1, 64'd2, 64'd3, 64'd4};
    for (int i = 0; i < 8; i++) chk("t1_model_pin", rq[i].d, expq[i]);
    ar_go(64'h28, 7, 3, 2);
    k = 0;
    while (!rvalid && k < 20) begin @(posedge clk); #1; k++; end
    chk("t1_latency", 64'(k), 64'd2);
    wait_read_done();
    expr = '{};
    chk_logs("t1_wrap");

    // 2: INCR write then read back
    do_write(64'h100, 3, 3, 1, 64'hA0, -1);
    chk("t2_bresp", {62'd0, last_bresp}, 64'd0);
    do_read(64'h100, 3, 3, 1);
    expq = '{64'hA0, 64'hA1, 64'hA2, 64'hA3};
    expr = '{64'd0, 64'd0, 64'd0, 64'd0};
    chk_logs("t2_readback");

    // 3: same-cycle AR and AW
    rlog.delete(); rresp_log.delete();
    push_read(64'h100, 3, 3, 1);
    model_write(64'h200, 0, 3, 1, 64'h55, -1, 1, 1'b1);
    araddr = 64'h100; arlen = 8'd3; arsize = 3'd3; arburst = 2'd1; arvalid = 1'b1;
    awaddr = 64'h200; awlen = 8'd0; awsize = 3'd3; awburst = 2'd1; awvalid = 1'b1;
    @(negedge clk);
    chk("t3_arready", {63'd0, arready}, 64'd1);
    chk("t3_awready_tie", {63'd0, awready}, 64'd0);
    @(posedge clk); #1 arvalid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      chk("t3_awready_busy", {63'd0, awready}, 64'd0);
      n++;
    end while (!(rvalid && rlast) && n < 50);
    @(negedge clk);
    chk("t3_awready_idle", {63'd0, awready}, 64'd1);
    @(posedge clk); #1 awvalid = 1'b0;
    w_beats(0, 64'h55, -1);
    wait_b_done();
    chk("t3_r_done", 64'(rq.size()), 64'd0);

    // 4: rready low for 3 cycles on the fourth beat
    rlog.delete(); rresp_log.delete();
    push_read(64'h0, 7, 3, 1);
    ar_go(64'h0, 7, 3, 1);
    stalled = 1'b0; n = 0;
    while (rq.size() > 0 && n < 200) begin
      if (!stalled && rvalid && rlog.size() == 3) begin
        rready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("t4_hold_rvalid", {63'd0, rvalid}, 64'd1);
          chk("t4_hold_rdata", rdata, 64'd3);
          chk("t4_hold_rlast", {63'd0, rlast}, 64'd0);
        end
        @(posedge clk); #1 rready = 1'b1;
        stalled = 1'b1;
      end
      @(posedge clk); #1; n++;
    end
    chk("t4_done", 64'(rq.size()), 64'd0);
    expq = '{64'd0, 64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd7};
    expr = '{};
    chk_logs("t4_stall");

    // 5: out-of-range read and write
    do_read(64'h8000, 1, 3, 1);
    expq = '{64'd0, 64'd0};
    expr = '{64'd2, 64'd2};
    chk_logs("t5_oor_read");
    do_write(64'h8000, 1, 3, 1, 64'hDEAD0000, -1);
    chk("t5_bresp", {62'd0, last_bresp}, 64'd2);
    do_read(64'h0, 1, 3, 1);
    expq = '{64'd0, 64'd1};
    expr = '{64'd0, 64'd0};
    chk_logs("t5_unchanged");

    // INCR rollover at 2^64: first beat out of range, second lands on word 0
    do_read(64'hFFFF_FFFF_FFFF_FFF8, 1, 3, 1);
    expq = '{64'd0, 64'd0};
    expr = '{64'd2, 64'd0};
    chk_logs("rollover");

    // FIXED, bad WRAP length, reserved burst, wrong size, single beat
    do_read(64'h8, 2, 3, 0);
    expq = '{64'd1, 64'd1, 64'd1};
    expr = '{64'd0, 64'd0, 64'd0};
    chk_logs("fixed");
    do_read(64'h0, 2, 3, 2);
    expq = '{64'd0, 64'd0, 64'd0};
    expr = '{64'd2, 64'd2, 64'd2};
    chk_logs("wrap_badlen");
    do_read(64'h0, 1, 3, 3);
    do_read(64'h0, 0, 2, 1);
    expq = '{64'd0};
    expr = '{64'd2};
    chk_logs("bad_size");
    do_read(64'h10, 0, 3, 1);
    expq = '{64'd2};
    expr = '{64'd0};
    chk_logs("single");

    // 6: reset after 2 of 4 write beats
    model_write(64'h200, 3, 3, 1, 64'hB0, -1, 2, 1'b0);
    aw_go(64'h200, 3, 3, 1);
    w_beats(1, 64'hB0, -1);
    reset = 1'b0;
    #1;
    chk("t6_rst_outputs", {arready, awready, rvalid, rlast, wready, bvalid, rresp, bresp}, 64'd0);
    chk("t6_rst_rdata", rdata, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("t6_idle_after_release", {63'd0, arready}, 64'd1);
    do_read(64'h200, 1, 3, 1);
    expq = '{64'hB0, 64'hB1};
    expr = '{64'd0, 64'd0};
    chk_logs("t6_persist");
    do_write(64'h300, 3, 3, 1, 64'hC0, 1);
    chk("t6_early_wlast_bresp", {62'd0, last_bresp}, 64'd2);
    do_read(64'h300, 3, 3, 1);
    expq = '{64'hC0, 64'hC1, 64'hC2, 64'hC3};
    expr = '{};
    chk_logs("t6_early_data");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
